// File: rtl/logic_seq_ctrl.sv
// Bit-serial driver for a shared 1-bit logical unit; result valid WIDTH cycles after accept.
// No new request is taken until the result is consumed; the result is held under res_ready backpressure.
module logic_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             busy,
    output logic             lu_a,
    output logic             lu_b,
    output logic             lu_s0,
    output logic             lu_s1,
    output logic             lu_s2,
    input  logic             lu_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       op_r_q, op_r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            op_r_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            op_r_q  <= op_r_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        op_r_d    = op_r_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        lu_a      = 1'b0;
        lu_b      = 1'b0;
        lu_s0     = 1'b0;
        lu_s1     = 1'b0;
        lu_s2     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = in_a;
                    b_sh_d  = in_b;
                    op_r_d  = in_op;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lu_a                = a_sh_q[0];
                lu_b                = b_sh_q[0];
                {lu_s2, lu_s1, lu_s0} = op_r_q;
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                // Result fills from the top so bit i lands at position i after WIDTH shifts.
                res_d               = {lu_out, res_q[WIDTH-1:1]};
                if (idx_q == CNTW'(WIDTH - 1)) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + CNTW'(1);
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign res_data = res_q;
    assign res_zero = (res_q == '0);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_seq_ctrl.sv
// Directed and random checks of logic_seq_ctrl against a behavioural 1-bit unit and word-level reference.
module tb_logic_seq_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             busy;
    logic             lu_a, lu_b, lu_s0, lu_s1, lu_s2;
    logic             lu_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .busy(busy),
        .lu_a(lu_a), .lu_b(lu_b), .lu_s0(lu_s0), .lu_s1(lu_s1), .lu_s2(lu_s2),
        .lu_out(lu_out)
    );

    function automatic logic unit_bit(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'b000:  return a & b;
            3'b010:  return ~(a & b);
            3'b001:  return a | b;
            3'b011:  return ~(a | b);
            3'b100:  return a ^ b;
            3'b111:  return ~(a ^ b);
            3'b101:  return a;
            3'b110:  return ~a;
            default: return 1'b0;
        endcase
    endfunction

    assign lu_out = unit_bit({lu_s2, lu_s1, lu_s0}, lu_a, lu_b);

    function automatic logic [WIDTH-1:0] ref_word(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b010:  return ~(a & b);
            3'b001:  return a | b;
            3'b011:  return ~(a | b);
            3'b100:  return a ^ b;
            3'b111:  return ~(a ^ b);
            3'b101:  return a;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("req_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        // Scramble the inputs to show they are only sampled at the accept edge.
        in_valid = 1'b0;
        in_op    = ~op;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] exp;
        exp = ref_word(op, a, b);
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, "_lu"}, 64'({lu_s2, lu_s1, lu_s0, lu_a, lu_b}), 64'({op, a[i], b[i]}));
            check({tag, "_run_flags"}, 64'({res_valid, in_ready, busy}), 64'(3'b001));
            @(posedge clk); #1;
        end
        check({tag, "_done_flags"}, 64'({res_valid, in_ready, busy}), 64'(3'b101));
        check({tag, "_data"}, 64'(res_data), 64'(exp));
        check({tag, "_zero"}, 64'(res_zero), 64'(exp == '0));
        check({tag, "_lu_idle"}, 64'({lu_s2, lu_s1, lu_s0, lu_a, lu_b}), 64'(0));
    endtask

    task automatic drain(input string tag, input int stall);
        logic [WIDTH-1:0] held;
        held      = res_data;
        res_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, 64'({res_valid, in_ready, res_data}), 64'({2'b10, held}));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_idle"}, 64'({res_valid, in_ready, busy}), 64'(3'b010));
    endtask

    task automatic full_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int stall);
        start_req(op, a, b);
        run_check(tag, op, a, b);
        drain(tag, stall);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 3'b000;
        res_ready = 1'b0;
        #1;
        check("reset_flags", 64'({res_valid, in_ready, busy, res_zero}), 64'(4'b0101));
        check("reset_lu", 64'({lu_s2, lu_s1, lu_s0, lu_a, lu_b}), 64'(0));
        check("reset_data", 64'(res_data), 64'(0));
        #12 rst = 1'b0;
        @(posedge clk); #1;

        full_op("and",  3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        full_op("xor",  3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        full_op("xnor", 3'b111, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        full_op("nota", 3'b110, 32'hF0F0_1234, 32'h1234_5678, 1);
        full_op("or",   3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        full_op("nor",  3'b011, 32'h0000_0000, 32'h0000_0000, 2);
        full_op("bufa", 3'b101, 32'h8000_0001, 32'hFFFF_FFFF, 0);
        full_op("andz", 3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        full_op("nand", 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);

        // Backpressure with a second request already waiting.
        start_req(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run_check("bp", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        in_valid = 1'b1;
        in_op    = 3'b100;
        in_a     = 32'hAAAA_5555;
        in_b     = 32'hFFFF_0000;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold", 64'({res_valid, in_ready, busy, res_data}), 64'({3'b101, 32'h00F0_1234}));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp_not_taken", 64'({res_valid, in_ready, busy}), 64'(3'b010));
        start_req(3'b100, 32'hAAAA_5555, 32'hFFFF_0000);
        run_check("bp2", 3'b100, 32'hAAAA_5555, 32'hFFFF_0000);
        check("bp2_value", 64'(res_data), 64'(32'h5555_5555));
        drain("bp2", 0);

        // Asynchronous reset in the middle of a NAND at idx 17.
        start_req(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF);
        repeat (17) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_flags", 64'({res_valid, in_ready, busy, res_zero}), 64'(4'b0101));
        check("arst_lu", 64'({lu_s2, lu_s1, lu_s0, lu_a, lu_b}), 64'(0));
        #3 rst = 1'b0;
        seen = 1'b0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        check("arst_no_result", 64'(seen), 64'(0));
        full_op("post_rst", 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        check("post_rst_val", 64'(ref_word(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF)), 64'(32'hFF0F_EDCB));

        for (int k = 0; k < 1000; k++) begin
            logic [2:0]       op;
            logic [WIDTH-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (k % 97 == 0) a = '0;
            full_op("rnd", op, a, b, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
